// File: rtl/bfp_normalizer_pkg.sv
// Shared types and helpers for the block-floating-point normalizer.
package bfp_normalizer_pkg;

    // Two-phase frame FSM: collect a frame, then stream it out.
    typedef enum logic [0:0] {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    // Redundant sign bits of the low w bits of v: the number of bits
    // directly below the sign bit that still equal the sign bit.
    // Range 0..w-1. A run flag is used instead of an early exit so the
    // loop unrolls into a plain priority chain.
    function automatic int rsb_calc(input logic [63:0] v, input int w);
        int   n;
        logic run;
        n   = 0;
        run = 1'b1;
        for (int i = 62; i >= 0; i--) begin
            if (i <= w - 2 && run) begin
                if (v[i] == v[w-1]) n = n + 1;
                else                run = 1'b0;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/bfp_normalizer_rsb_count.sv
// Combinational leading-sign counter for one WIDTH-bit signed sample.
module rsb_count
    import bfp_normalizer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int RSB_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] data,
    output logic [RSB_W-1:0] rsb
);

    // Count sign-bit repeats below the MSB.
    always_comb begin
        rsb = RSB_W'(rsb_calc(64'(data), WIDTH));
    end

endmodule

// File: rtl/bfp_normalizer.sv
// Block-floating-point normalizer: buffers FRAME_LEN samples, finds the
// smallest redundant-sign-bit count across the frame, then replays the
// samples unmodified alongside that common left-shift amount.
module bfp_normalizer
    import bfp_normalizer_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int SHIFT_BITS = 3,
    parameter int FRAME_LEN  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic [WIDTH-1:0]      in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [SHIFT_BITS-1:0] out_shift,
    output logic                  out_dir,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last
);

    localparam int PTR_W     = $clog2(FRAME_LEN);
    localparam int RSB_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int SHIFT_MAX = (1 << SHIFT_BITS) - 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(FRAME_LEN - 1);

    state_t                   state;
    logic [PTR_W-1:0]         wr_ptr;
    logic [PTR_W-1:0]         rd_ptr;
    logic [RSB_W-1:0]         run_min;
    logic [RSB_W-1:0]         cur_rsb;
    logic [RSB_W-1:0]         frame_min;
    logic [SHIFT_BITS-1:0]    shift_clamped;
    logic [WIDTH-1:0]         buffer [FRAME_LEN];
    logic                     in_acc;
    logic                     out_acc;

    rsb_count #(.WIDTH(WIDTH), .RSB_W(RSB_W)) u_rsb (
        .data (in_data),
        .rsb  (cur_rsb)
    );

    // Handshake-facing outputs are pure decodes of state so that an
    // asynchronous reset drops out_valid immediately.
    always_comb begin
        in_ready  = (state == FILL);
        out_valid = (state == DRAIN);
        out_last  = (state == DRAIN) && (rd_ptr == LAST_IDX);
        out_data  = buffer[rd_ptr];
        out_dir   = 1'b0;
        in_acc    = in_valid && in_ready;
        out_acc   = out_valid && out_ready;
    end

    // Minimum including the current sample; the first sample of a frame
    // seeds the minimum so stale state never leaks across frames.
    always_comb begin
        if (wr_ptr == '0)            frame_min = cur_rsb;
        else if (cur_rsb < run_min)  frame_min = cur_rsb;
        else                         frame_min = run_min;
        if (32'(frame_min) > SHIFT_MAX) shift_clamped = SHIFT_BITS'(SHIFT_MAX);
        else                            shift_clamped = SHIFT_BITS'(frame_min);
    end

    // Frame FSM, pointers, running minimum and latched shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FILL;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            run_min   <= '1;
            out_shift <= '0;
        end else if (clear) begin
            state   <= FILL;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            run_min <= '1;
        end else begin
            case (state)
                FILL: begin
                    if (in_acc) begin
                        run_min <= frame_min;
                        if (wr_ptr == LAST_IDX) begin
                            wr_ptr    <= '0;
                            state     <= DRAIN;
                            out_shift <= shift_clamped;
                        end else begin
                            wr_ptr <= wr_ptr + PTR_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (out_acc) begin
                        if (rd_ptr == LAST_IDX) begin
                            rd_ptr <= '0;
                            state  <= FILL;
                        end else begin
                            rd_ptr <= rd_ptr + PTR_W'(1);
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    // Sample storage; contents are don't-care until rewritten, so no reset.
    always_ff @(posedge clk) begin
        if (in_acc && !clear) buffer[wr_ptr] <= in_data;
    end

endmodule
